// File: rtl/keypad_scanner_if.sv
// -----------------------------------------------------------------------------
// keypad_scanner_if
// Bundles the keypad-facing lines and the decoded key outputs of
// keypad_scanner.
//   rows      : keypad row lines, active-low, asynchronous to clk
//   cols      : column drives, active-low, exactly one bit low
//   key_code  : hex value of the last accepted key
//   key_valid : one-cycle pulse when key_code is updated
//   key_held  : high while the accepted key is considered pressed
// modport slave  : the scanner itself
// modport master : the environment (keypad model / key consumer)
// -----------------------------------------------------------------------------
interface keypad_scanner_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    output rows,
    input  cols,
    input  key_code,
    input  key_valid,
    input  key_held
  );

  modport slave (
    input  rows,
    output cols,
    output key_code,
    output key_valid,
    output key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time, assembles a
// 16-bit frame per full scan, and debounces single-key presses and releases
// over DEBOUNCE_SCANS consecutive frames.
// Ports:
//   clk   : system clock (only clock used)
//   reset : asynchronous, active-high reset
//   kp    : keypad_scanner_if.slave (rows in; cols, key_code, key_valid,
//           key_held out)
// Parameters:
//   SCAN_TICKS     : clk cycles per column slot (>= 4)
//   DEBOUNCE_SCANS : stable frames needed to accept a press/release (>= 2)
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_TICKS     = 100_000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic            clk,
  input  logic            reset,
  keypad_scanner_if.slave kp
);

  localparam int SLOT_W = $clog2(SCAN_TICKS);
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_TICKS - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  // Frame bit index is {column, row}; returns the legend of that key.
  function automatic logic [3:0] key_lut(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'h0: code = 4'h1;  4'h1: code = 4'h4;  4'h2: code = 4'h7;  4'h3: code = 4'h0;
      4'h4: code = 4'h2;  4'h5: code = 4'h5;  4'h6: code = 4'h8;  4'h7: code = 4'hF;
      4'h8: code = 4'h3;  4'h9: code = 4'h6;  4'hA: code = 4'h9;  4'hB: code = 4'hE;
      4'hC: code = 4'hA;  4'hD: code = 4'hB;  4'hE: code = 4'hC;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // ---------------------------------------------------------------- sync
  logic [3:0] rows_meta_q, rows_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_meta_q <= 4'hF;
      rows_sync_q <= 4'hF;
    end else begin
      rows_meta_q <= kp.rows;
      rows_sync_q <= rows_meta_q;
    end
  end

  // ---------------------------------------------------------------- scan
  logic [SLOT_W-1:0] slot_q;
  logic [1:0]        col_q;
  logic [11:0]       frame_q;   // columns 0..2; column 3 is taken live at frame end
  logic              slot_last, frame_end;
  logic [15:0]       frame_now;

  assign slot_last = (slot_q == SLOT_LAST);
  assign frame_end = slot_last && (col_q == 2'd3);
  assign frame_now = {~rows_sync_q, frame_q};
  assign kp.cols   = ~(4'b0001 << col_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q  <= '0;
      col_q   <= 2'd0;
      frame_q <= '0;
    end else begin
      if (slot_last) begin
        slot_q <= '0;
        col_q  <= col_q + 2'd1;
      end else begin
        slot_q <= slot_q + SLOT_W'(1);
      end
      for (int c = 0; c < 3; c++) begin
        if (slot_last && col_q == 2'(c)) frame_q[c*4 +: 4] <= ~rows_sync_q;
      end
    end
  end

  // ---------------------------------------------------------------- classify
  logic [4:0] hits;
  logic [3:0] hit_idx;
  logic       is_none, is_single;
  logic [3:0] hit_code;

  always_comb begin
    hits    = 5'd0;
    hit_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_now[i]) begin
        hits    = hits + 5'd1;
        hit_idx = 4'(i);
      end
    end
  end

  assign is_none   = (hits == 5'd0);
  assign is_single = (hits == 5'd1);
  assign hit_code  = key_lut(hit_idx);

  // ---------------------------------------------------------------- FSM
  state_t           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cand_q      <= 4'd0;
      cnt_q       <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (is_single) begin
            cand_d  = hit_code;
            cnt_d   = CNT_W'(1);
            state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!is_single) begin
            state_d = IDLE;
          end else if (hit_code != cand_q) begin
            // A different key restarts the stability count on that key.
            cand_d = hit_code;
            cnt_d  = CNT_W'(1);
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_d     = PRESSED;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
            end
          end
        end
        PRESSED: begin
          // Any key activity keeps the press alive; no repeat, no roll-over.
          if (is_none) begin
            cnt_d   = CNT_W'(1);
            state_d = RELEASE;
          end
        end
        default: begin // RELEASE
          if (!is_none) begin
            state_d = PRESSED;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) state_d = IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    key_held = (state_q == PRESSED) || (state_q == RELEASE);
  end

  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  logic        clk;
  logic        reset;
  logic [15:0] mask;      // pressed keys, bit index row*4 + column
  logic [3:0]  rows_drv;

  int checks    = 0;
  int fails     = 0;
  int valid_cnt = 0;
  int glitch    = 0;
  int cyc       = 0;
  int base;
  logic [3:0] prev_code = 4'd0;
  logic [3:0] one4 = 4'b0001;

  keypad_scanner_if kp_if ();

  keypad_scanner #(
    .SCAN_TICKS    (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kp   (kp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive matrix: a pressed key shorts its row to its column drive.
  always_comb begin
    rows_drv = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (mask[r*4+c] && !kp_if.cols[c]) rows_drv[r] = 1'b0;
      end
    end
  end
  assign kp_if.rows = rows_drv;

  // Count key_valid pulses and any key_code change not flagged by key_valid.
  always @(negedge clk) begin
    if (kp_if.key_valid === 1'b1) valid_cnt = valid_cnt + 1;
    if (reset === 1'b0 && kp_if.key_code !== prev_code && kp_if.key_valid !== 1'b1)
      glitch = glitch + 1;
    prev_code = kp_if.key_code;
  end

  function automatic logic [15:0] key(input int r, input int c);
    logic [15:0] b;
    b = 16'd1;
    return b << (r*4 + c);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic check_cols(input string tag, input int col);
    logic [3:0] exp;
    exp = ~(one4 << col);
    chk(tag, {12'd0, kp_if.cols}, {12'd0, exp});
  endtask

  initial begin
    reset = 1'b1;
    mask  = 16'd0;

    // Reset state
    cycles(2);
    check_cols("rst_cols", 0);
    chk("rst_valid", {15'd0, kp_if.key_valid}, 16'd0);
    chk("rst_held",  {15'd0, kp_if.key_held},  16'd0);
    chk("rst_code",  {12'd0, kp_if.key_code},  16'd0);
    reset = 1'b0;
    cyc = 0;
    $display("step reset: cols=%b held=%b code=%h", kp_if.cols, kp_if.key_held, kp_if.key_code);

    // Idle scan for 10 frames: 4 cycles per column, no key activity
    for (int k = 0; k < 160; k++) begin
      check_cols("idle_cols", (k / 4) % 4);
      cycles(1);
    end
    chk("idle_valid_cnt", 16'(valid_cnt), 16'd0);
    chk("idle_held", {15'd0, kp_if.key_held}, 16'd0);
    $display("step idle scan: 10 frames, valid pulses=%0d", valid_cnt);

    // Key 6 (row1, col2): accepted at end of frame 3, released after 3 NONE frames
    mask = key(1, 2);
    do_reset();
    base = valid_cnt;
    cycles(47);
    chk("k6_no_early_valid", {15'd0, kp_if.key_valid}, 16'd0);
    cycles(1);
    chk("k6_valid", {15'd0, kp_if.key_valid}, 16'd1);
    chk("k6_code",  {12'd0, kp_if.key_code},  16'h6);
    chk("k6_held",  {15'd0, kp_if.key_held},  16'd1);
    cycles(1);
    chk("k6_valid_one_cycle", {15'd0, kp_if.key_valid}, 16'd0);
    mask = 16'd0;
    cycles(46);
    chk("k6_held_in_release", {15'd0, kp_if.key_held}, 16'd1);
    cycles(1);
    chk("k6_held_dropped", {15'd0, kp_if.key_held}, 16'd0);
    chk("k6_valid_count", 16'(valid_cnt - base), 16'd1);
    $display("step key6: code=%h pulses=%0d", kp_if.key_code, valid_cnt - base);

    // Key 5 for one frame, then key 9 for three frames
    mask = key(1, 1);
    do_reset();
    base = valid_cnt;
    cycles(12);
    mask = key(2, 2);
    cycles(51);
    chk("k9_no_early_valid", {15'd0, kp_if.key_valid}, 16'd0);
    cycles(1);
    chk("k9_valid", {15'd0, kp_if.key_valid}, 16'd1);
    chk("k9_code",  {12'd0, kp_if.key_code},  16'h9);
    mask = 16'd0;
    cycles(48);
    chk("k9_held_dropped", {15'd0, kp_if.key_held}, 16'd0);
    chk("k9_valid_count", 16'(valid_cnt - base), 16'd1);
    $display("step key5->key9: code=%h pulses=%0d", kp_if.key_code, valid_cnt - base);

    // Keys 1 and D together for 5 frames: ignored, code keeps 9
    base = valid_cnt;
    mask = key(0, 0) | key(3, 3);
    cycles(80);
    chk("multi_held", {15'd0, kp_if.key_held}, 16'd0);
    mask = 16'd0;
    cycles(48);
    chk("multi_valid_count", 16'(valid_cnt - base), 16'd0);
    chk("multi_code_kept", {12'd0, kp_if.key_code}, 16'h9);
    $display("step keys1+D: code=%h pulses=%0d", kp_if.key_code, valid_cnt - base);

    // Key A pressed; reset pulsed asynchronously in frame 2 (debouncing)
    base = valid_cnt;
    mask = key(0, 3);
    cycles(22);
    chk("abort_held_before", {15'd0, kp_if.key_held}, 16'd0);
    check_cols("abort_cols_before", 1);
    #2;
    reset = 1'b1;
    #1;
    check_cols("abort_cols_async", 0);
    chk("abort_code_async",  {12'd0, kp_if.key_code},  16'd0);
    chk("abort_valid_async", {15'd0, kp_if.key_valid}, 16'd0);
    chk("abort_held_async",  {15'd0, kp_if.key_held},  16'd0);
    mask = 16'd0;
    cycles(2);
    reset = 1'b0;
    cyc = 0;
    check_cols("abort_restart_c0", 0);
    cycles(3);
    check_cols("abort_restart_c0_end", 0);
    cycles(1);
    check_cols("abort_restart_c1", 1);
    cycles(60);
    chk("abort_valid_count", 16'(valid_cnt - base), 16'd0);
    chk("abort_held_after",  {15'd0, kp_if.key_held}, 16'd0);
    $display("step reset-abort: code=%h pulses=%0d", kp_if.key_code, valid_cnt - base);

    // Key 0 accepted, released for one frame, pressed again: single pulse
    mask = key(3, 0);
    do_reset();
    base = valid_cnt;
    cycles(48);
    chk("k0_valid", {15'd0, kp_if.key_valid}, 16'd1);
    chk("k0_code",  {12'd0, kp_if.key_code},  16'h0);
    mask = 16'd0;
    for (int k = 0; k < 16; k++) begin
      cycles(1);
      chk("k0_held_gap", {15'd0, kp_if.key_held}, 16'd1);
    end
    mask = key(3, 0);
    for (int k = 0; k < 32; k++) begin
      cycles(1);
      chk("k0_held_repress", {15'd0, kp_if.key_held}, 16'd1);
    end
    mask = 16'd0;
    cycles(64);
    chk("k0_held_dropped", {15'd0, kp_if.key_held}, 16'd0);
    chk("k0_valid_count", 16'(valid_cnt - base), 16'd1);
    $display("step key0 bounce: code=%h pulses=%0d", kp_if.key_code, valid_cnt - base);

    chk("code_change_without_valid", 16'(glitch), 16'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
